// File: rtl/lcd_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl_gen
// Loads a W x H image from ROM, applies 2x2 window commands, streams to IRB.
// Revision : 1.0
// ============================================================================
module lcd_ctrl_gen #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int AW   = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] irom_q,
  output logic          irom_en,
  output logic [AW-1:0] irom_a,
  output logic          irb_rw,
  output logic [AW-1:0] irb_a,
  output logic [DW-1:0] irb_d,
  output logic          busy,
  output logic          done
);

  localparam int c_xw = $clog2(IMG_W);
  localparam int c_yw = $clog2(IMG_H);

  localparam logic [AW:0]     c_npix     = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW:0]     c_load_end = (AW+1)'(IMG_W * IMG_H + 1);
  localparam logic [c_xw-1:0] c_wx_init  = c_xw'(IMG_W / 2 - 1);
  localparam logic [c_yw-1:0] c_wy_init  = c_yw'(IMG_H / 2 - 1);
  localparam logic [c_xw-1:0] c_wx_max   = c_xw'(IMG_W - 2);
  localparam logic [c_yw-1:0] c_wy_max   = c_yw'(IMG_H - 2);

  localparam logic [3:0] c_cmd_write  = 4'd0;
  localparam logic [3:0] c_cmd_up     = 4'd1;
  localparam logic [3:0] c_cmd_down   = 4'd2;
  localparam logic [3:0] c_cmd_left   = 4'd3;
  localparam logic [3:0] c_cmd_right  = 4'd4;
  localparam logic [3:0] c_cmd_avg    = 4'd5;
  localparam logic [3:0] c_cmd_mirx   = 4'd6;
  localparam logic [3:0] c_cmd_miry   = 4'd7;
  localparam logic [3:0] c_cmd_max    = 4'd8;
  localparam logic [3:0] c_cmd_min    = 4'd9;
  localparam logic [3:0] c_cmd_rotcw  = 4'd10;
  localparam logic [3:0] c_cmd_rotccw = 4'd11;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nx;
  logic [AW:0]     r_cnt, w_cnt_nx;
  logic [3:0]      r_cmd, w_cmd_nx;
  logic [c_xw-1:0] r_wx;
  logic [c_yw-1:0] r_wy;
  logic            r_irom_en, w_irom_en_nx;
  logic [AW-1:0]   r_irom_a, w_irom_a_nx;
  logic            r_cap_en;
  logic [AW-1:0]   r_cap_a;
  logic            r_irb_rw, w_irb_rw_nx;
  logic [AW-1:0]   r_irb_a, w_irb_a_nx;
  logic [DW-1:0]   r_irb_d, w_irb_d_nx;
  logic [DW-1:0]   r_buf [IMG_W*IMG_H];

  logic [AW-1:0]   w_cnt_idx;
  logic [c_xw-1:0] w_wx1;
  logic [c_yw-1:0] w_wy1;
  logic [AW-1:0]   w_k0, w_k1, w_k2, w_k3;
  logic [DW-1:0]   w_p0, w_p1, w_p2, w_p3;
  logic [DW-1:0]   w_n0, w_n1, w_n2, w_n3;
  logic [DW+1:0]   w_sum;
  logic [DW-1:0]   w_avg, w_max01, w_max23, w_max, w_min01, w_min23, w_min;
  logic            w_we;

  assign w_cnt_idx = r_cnt[AW-1:0];

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_cmd_nx     = r_cmd;
    w_irom_en_nx = 1'b0;
    w_irom_a_nx  = r_irom_a;
    w_irb_rw_nx  = 1'b1;
    w_irb_a_nx   = r_irb_a;
    w_irb_d_nx   = r_irb_d;
    case (r_state)
      S_LOAD: begin
        if (r_cnt < c_npix) begin
          w_irom_en_nx = 1'b1;
          w_irom_a_nx  = w_cnt_idx;
        end
        // One extra cycle lets the last ROM word come back before IDLE.
        if (r_cnt == c_load_end) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          w_cmd_nx   = cmd;
          w_cnt_nx   = '0;
          w_state_nx = (cmd == c_cmd_write) ? S_WRITE : S_EXEC;
        end
      end
      S_EXEC: w_state_nx = S_IDLE;
      S_WRITE: begin
        if (r_cnt == c_npix) begin
          w_state_nx = S_DONE;
        end else begin
          w_irb_rw_nx = 1'b0;
          w_irb_a_nx  = w_cnt_idx;
          w_irb_d_nx  = r_buf[w_cnt_idx];
        end
        w_cnt_nx = r_cnt + 1'b1;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_irom_en <= 1'b0;
      r_irom_a  <= '0;
      r_cap_en  <= 1'b0;
      r_cap_a   <= '0;
      r_irb_rw  <= 1'b1;
      r_irb_a   <= '0;
      r_irb_d   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_cmd     <= w_cmd_nx;
      r_irom_en <= w_irom_en_nx;
      r_irom_a  <= w_irom_a_nx;
      r_cap_en  <= r_irom_en;
      r_cap_a   <= r_irom_a;
      r_irb_rw  <= w_irb_rw_nx;
      r_irb_a   <= w_irb_a_nx;
      r_irb_d   <= w_irb_d_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wx <= c_wx_init;
      r_wy <= c_wy_init;
    end else if (r_state == S_EXEC) begin
      case (r_cmd)
        c_cmd_up:    if (r_wy != '0)      r_wy <= r_wy - 1'b1;
        c_cmd_down:  if (r_wy < c_wy_max) r_wy <= w_wy1;
        c_cmd_left:  if (r_wx != '0)      r_wx <= r_wx - 1'b1;
        c_cmd_right: if (r_wx < c_wx_max) r_wx <= w_wx1;
        default: ;
      endcase
    end
  end

  // Window never touches the right/bottom edge, so +1 cannot wrap.
  assign w_wx1 = r_wx + 1'b1;
  assign w_wy1 = r_wy + 1'b1;
  assign w_k0  = {r_wy,  r_wx};
  assign w_k1  = {r_wy,  w_wx1};
  assign w_k2  = {w_wy1, r_wx};
  assign w_k3  = {w_wy1, w_wx1};
  assign w_p0  = r_buf[w_k0];
  assign w_p1  = r_buf[w_k1];
  assign w_p2  = r_buf[w_k2];
  assign w_p3  = r_buf[w_k3];

  assign w_sum   = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};
  assign w_avg   = DW'(w_sum >> 2);
  assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
  assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
  assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
  assign w_min01 = (w_p0 < w_p1) ? w_p0 : w_p1;
  assign w_min23 = (w_p2 < w_p3) ? w_p2 : w_p3;
  assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;

  always_comb begin
    w_we = 1'b1;
    w_n0 = w_p0;
    w_n1 = w_p1;
    w_n2 = w_p2;
    w_n3 = w_p3;
    case (r_cmd)
      c_cmd_avg:    begin w_n0 = w_avg; w_n1 = w_avg; w_n2 = w_avg; w_n3 = w_avg; end
      c_cmd_mirx:   begin w_n0 = w_p2;  w_n1 = w_p3;  w_n2 = w_p0;  w_n3 = w_p1;  end
      c_cmd_miry:   begin w_n0 = w_p1;  w_n1 = w_p0;  w_n2 = w_p3;  w_n3 = w_p2;  end
      c_cmd_max:    begin w_n0 = w_max; w_n1 = w_max; w_n2 = w_max; w_n3 = w_max; end
      c_cmd_min:    begin w_n0 = w_min; w_n1 = w_min; w_n2 = w_min; w_n3 = w_min; end
      c_cmd_rotcw:  begin w_n0 = w_p2;  w_n1 = w_p0;  w_n2 = w_p3;  w_n3 = w_p1;  end
      c_cmd_rotccw: begin w_n0 = w_p1;  w_n1 = w_p3;  w_n2 = w_p0;  w_n3 = w_p2;  end
      default:      w_we = 1'b0;
    endcase
  end

  // All four window writes use pre-update pixel values and land together.
  always_ff @(posedge clk) begin
    if (r_cap_en) begin
      r_buf[r_cap_a] <= irom_q;
    end else if (r_state == S_EXEC && w_we) begin
      r_buf[w_k0] <= w_n0;
      r_buf[w_k1] <= w_n1;
      r_buf[w_k2] <= w_n2;
      r_buf[w_k3] <= w_n3;
    end
  end

  assign irom_en = r_irom_en;
  assign irom_a  = r_irom_a;
  assign irb_rw  = r_irb_rw;
  assign irb_a   = r_irb_a;
  assign irb_d   = r_irb_d;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_ctrl_gen
// Directed self-checking bench for lcd_ctrl_gen (8x8/DW8 and 16x4/DW10).
// Revision : 1.0
// ============================================================================
module tb_lcd_ctrl_gen;

  logic       clk;
  logic       reset;
  logic [3:0] cmd0, cmd1;
  logic       cmd_valid0, cmd_valid1;
  logic [7:0] irom_q0;
  logic       irom_en0;
  logic [5:0] irom_a0;
  logic       irb_rw0;
  logic [5:0] irb_a0;
  logic [7:0] irb_d0;
  logic       busy0, done0;
  logic [9:0] irom_q1;
  logic       irom_en1;
  logic [5:0] irom_a1;
  logic       irb_rw1;
  logic [5:0] irb_a1;
  logic [9:0] irb_d1;
  logic       busy1, done1;

  logic [7:0] rom0 [64];
  logic [7:0] exp0 [64];
  logic [9:0] rom1 [64];
  logic [9:0] exp1 [64];
  logic [9:0] cap1 [64];

  int checks   = 0;
  int failures = 0;

  lcd_ctrl_gen #(.DW(8), .IMG_W(8), .IMG_H(8)) u_dut0 (
    .clk(clk), .reset(reset), .cmd(cmd0), .cmd_valid(cmd_valid0),
    .irom_q(irom_q0), .irom_en(irom_en0), .irom_a(irom_a0),
    .irb_rw(irb_rw0), .irb_a(irb_a0), .irb_d(irb_d0),
    .busy(busy0), .done(done0)
  );

  lcd_ctrl_gen #(.DW(10), .IMG_W(16), .IMG_H(4)) u_dut1 (
    .clk(clk), .reset(reset), .cmd(cmd1), .cmd_valid(cmd_valid1),
    .irom_q(irom_q1), .irom_en(irom_en1), .irom_a(irom_a1),
    .irb_rw(irb_rw1), .irb_a(irb_a1), .irb_d(irb_d1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (irom_en0) irom_q0 <= rom0[irom_a0];
    if (irom_en1) irom_q1 <= rom1[irom_a1];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle0;
    int n = 0;
    while (busy0 && n < 300) begin tick(); n++; end
    if (busy0) begin
      checks++; failures++;
      $display("FAIL idle0_timeout busy=%0b required 0", busy0);
    end
  endtask

  task automatic wait_idle1;
    int n = 0;
    while (busy1 && n < 300) begin tick(); n++; end
    if (busy1) begin
      checks++; failures++;
      $display("FAIL idle1_timeout busy=%0b required 0", busy1);
    end
  endtask

  task automatic send0(input logic [3:0] c);
    wait_idle0();
    cmd0 = c; cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [3:0] c);
    wait_idle1();
    cmd1 = c; cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
  endtask

  task automatic reload0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    wait_idle0();
  endtask

  task automatic exp_from_rom0;
    for (int k = 0; k < 64; k++) exp0[k] = rom0[k];
  endtask

  // Issue Write on dut0 and check the full stream, done pulse and return to idle.
  task automatic test_write_stream(input string nm, input bit hold);
    int n = 0;
    wait_idle0();
    cmd0 = 4'd0; cmd_valid0 = 1'b1;
    tick();
    if (hold) cmd0 = 4'd4;
    else cmd_valid0 = 1'b0;
    while (irb_rw0 && n < 10) begin tick(); n++; end
    for (int c = 0; c < 64; c++) begin
      checks++;
      if (irb_rw0 !== 1'b0 || irb_a0 !== 6'(c) || irb_d0 !== exp0[c]) begin
        failures++;
        $display("FAIL %s_stream c=%0d got rw=%0b a=%0d d=%0d required rw=0 a=%0d d=%0d",
                 nm, c, irb_rw0, irb_a0, irb_d0, c, exp0[c]);
      end
      tick();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b1 || irb_rw0 !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got done=%0b busy=%0b rw=%0b required 1 1 1", nm, done0, busy0, irb_rw0);
    end
    cmd_valid0 = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL %s_after got done=%0b busy=%0b required 0 0", nm, done0, busy0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (irom_en0 !== 1'b0 || irom_a0 !== 6'd0) begin
      failures++;
      $display("FAIL reset_irom got en=%0b a=%0d required 0 0", irom_en0, irom_a0);
    end
    checks++;
    if (irb_rw0 !== 1'b1 || irb_a0 !== 6'd0 || irb_d0 !== 8'd0) begin
      failures++;
      $display("FAIL reset_irb got rw=%0b a=%0d d=%0d required 1 0 0", irb_rw0, irb_a0, irb_d0);
    end
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%0b done=%0b required 1 0", busy0, done0);
    end
    reset = 1'b0;
    for (int c = 0; c <= 64; c++) begin
      tick();
      checks++;
      if (c < 64) begin
        if (irom_en0 !== 1'b1 || irom_a0 !== 6'(c) || busy0 !== 1'b1) begin
          failures++;
          $display("FAIL load_seq c=%0d got en=%0b a=%0d busy=%0b required 1 %0d 1", c, irom_en0, irom_a0, busy0, c);
        end
      end else if (irom_en0 !== 1'b0 || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL load_last got en=%0b busy=%0b required 0 1", irom_en0, busy0);
      end
    end
    tick();
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL load_idle got busy=%0b required 0", busy0);
    end
  endtask

  task automatic test_write;
    exp_from_rom0();
    test_write_stream("write1", 1'b0);
  endtask

  task automatic test_back_to_back;
    exp_from_rom0();
    test_write_stream("write2", 1'b0);
  endtask

  task automatic test_shift_avg;
    reload0();
    for (int i = 0; i < 5; i++) send0(4'd1);
    send0(4'd5);
    exp_from_rom0();
    exp0[3] = 8'd7; exp0[4] = 8'd7; exp0[11] = 8'd7; exp0[12] = 8'd7;
    test_write_stream("up_avg", 1'b0);
  endtask

  task automatic test_ops;
    rom0[27] = 8'd1; rom0[28] = 8'd2; rom0[35] = 8'd3; rom0[36] = 8'd5;
    reload0();
    send0(4'd5);
    exp_from_rom0();
    exp0[27] = 8'd2; exp0[28] = 8'd2; exp0[35] = 8'd2; exp0[36] = 8'd2;
    test_write_stream("avg", 1'b0);

    reload0();
    send0(4'd8);
    exp_from_rom0();
    exp0[27] = 8'd5; exp0[28] = 8'd5; exp0[35] = 8'd5; exp0[36] = 8'd5;
    test_write_stream("max", 1'b0);

    reload0();
    send0(4'd10);
    exp_from_rom0();
    exp0[27] = 8'd3; exp0[28] = 8'd1; exp0[35] = 8'd5; exp0[36] = 8'd2;
    test_write_stream("rotcw", 1'b0);

    reload0();
    send0(4'd6);
    send0(4'd11);
    send0(4'd7);
    exp_from_rom0();
    exp0[27] = 8'd2; exp0[28] = 8'd5; exp0[35] = 8'd1; exp0[36] = 8'd3;
    test_write_stream("mir_ccw", 1'b0);

    send0(4'd9);
    send0(4'd12);
    send0(4'd3);
    send0(4'd2);
    send0(4'd8);
    exp0[27] = 8'd1; exp0[28] = 8'd1; exp0[36] = 8'd1;
    exp0[34] = 8'd43; exp0[35] = 8'd43; exp0[42] = 8'd43; exp0[43] = 8'd43;
    test_write_stream("min_move_max", 1'b0);

    for (int k = 0; k < 64; k++) rom0[k] = 8'(k);
  endtask

  task automatic test_hold_valid;
    reload0();
    cmd0 = 4'd4; cmd_valid0 = 1'b1;
    tick(); tick(); tick(); tick();
    cmd_valid0 = 1'b0;
    exp_from_rom0();
    test_write_stream("hold_write", 1'b1);
    send0(4'd5);
    exp0[29] = 8'd33; exp0[30] = 8'd33; exp0[37] = 8'd33; exp0[38] = 8'd33;
    test_write_stream("hold_avg", 1'b0);
  endtask

  task automatic test_shift_sat;
    reload0();
    for (int i = 0; i < 10; i++) send0(4'd4);
    send0(4'd5);
    exp_from_rom0();
    exp0[30] = 8'd34; exp0[31] = 8'd34; exp0[38] = 8'd34; exp0[39] = 8'd34;
    test_write_stream("right_sat", 1'b0);
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    int cnt = 0;
    wait_idle0();
    cmd0 = 4'd0; cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    while (!(irb_rw0 === 1'b0 && irb_a0 === 6'd20) && n < 100) begin tick(); n++; end
    checks++;
    if (irb_rw0 !== 1'b0 || irb_a0 !== 6'd20) begin
      failures++;
      $display("FAIL midwr_reach got rw=%0b a=%0d required 0 20", irb_rw0, irb_a0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (irb_rw0 !== 1'b1 || irb_a0 !== 6'd0 || irb_d0 !== 8'd0 || irom_en0 !== 1'b0) begin
      failures++;
      $display("FAIL midwr_reset_irb got rw=%0b a=%0d d=%0d en=%0b required 1 0 0 0", irb_rw0, irb_a0, irb_d0, irom_en0);
    end
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL midwr_reset_flags got busy=%0b done=%0b required 1 0", busy0, done0);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (irom_en0 !== 1'b1 || irom_a0 !== 6'd0) begin
          failures++;
          $display("FAIL reload_start got en=%0b a=%0d required 1 0", irom_en0, irom_a0);
        end
      end
      if (!busy0) break;
      cnt++;
    end
    checks++;
    if (cnt !== 65) begin
      failures++;
      $display("FAIL reload_busy_cycles got %0d required 65", cnt);
    end
  endtask

  task automatic test_wide;
    int wr = 0;
    for (int k = 0; k < 64; k++) cap1[k] = '0;
    send1(4'd5);
    send1(4'd2);
    send1(4'd2);
    send1(4'd2);
    send1(4'd9);
    for (int k = 0; k < 64; k++) exp1[k] = rom1[k];
    exp1[23] = 10'd1023; exp1[24] = 10'd1023;
    exp1[39] = 10'd55; exp1[40] = 10'd55; exp1[55] = 10'd55; exp1[56] = 10'd55;
    wait_idle1();
    cmd1 = 4'd0; cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (irb_rw1 === 1'b0) begin
        cap1[irb_a1] = irb_d1;
        wr++;
      end
      if (done1 === 1'b1) break;
    end
    checks++;
    if (wr !== 64 || done1 !== 1'b1) begin
      failures++;
      $display("FAIL wide_stream got writes=%0d done=%0b required 64 1", wr, done1);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (cap1[k] !== exp1[k]) begin
        failures++;
        $display("FAIL wide_pix k=%0d got %0d required %0d", k, cap1[k], exp1[k]);
      end
    end
    tick();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL wide_after got busy=%0b done=%0b required 0 0", busy1, done1);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd0 = 4'd0; cmd1 = 4'd0;
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      rom0[k] = 8'(k);
      rom1[k] = 10'(k);
    end
    rom1[23] = 10'd1023; rom1[24] = 10'd1023; rom1[39] = 10'd1023; rom1[40] = 10'd1023;

    test_reset();
    test_write();
    test_back_to_back();
    test_shift_avg();
    test_ops();
    test_hold_valid();
    test_shift_sat();
    test_reset_mid_write();
    test_wide();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
